// File: rtl/isqrt_seq.sv
// -----------------------------------------------------------------------------
// isqrt_seq
// -----------------------------------------------------------------------------
// Sequential unsigned integer square root. Each clock in CALC produces one root
// bit using the digit-by-digit restoring method. Root bits come out MSB first.
// A 2N-bit operand takes N iterations. The unit then spends one cycle in DONE
// and returns to IDLE.
//
// Result relation: X = root*root + rem, where 0 <= rem <= 2*root.
//
// Ports
//   clk    in   1     system clock; every state change happens on the rising edge
//   rst    in   1     synchronous reset, active-high; aborts any operation
//   start  in   1     request; only looked at while idle
//   X      in   2N    unsigned operand; captured on the edge that accepts start
//   busy   out  1     high while an operation is in progress or completing
//   done   out  1     one-cycle pulse; root/rem hold the new result in this cycle
//   root   out  N     floor(sqrt(X)); registered, stable until the next completion
//   rem    out  N+1   X - root*root; registered, stable until the next completion
// -----------------------------------------------------------------------------
module isqrt_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] X,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   root,
  output logic [N:0]     rem
);

  // The iteration counter runs from N-1 down to 0.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2*N-1:0]   opr_q,   opr_d;    // operand, consumed two bits per step
  logic [N-1:0]     proot_q, proot_d;  // partial root
  logic [N:0]       prem_q,  prem_d;   // partial remainder
  logic [CW-1:0]    cnt_q,   cnt_d;    // steps remaining after this one
  logic [N-1:0]     root_q,  root_d;   // published result
  logic [N:0]       rem_q,   rem_d;

  // ---------------------------------------------------------------------------
  // Trial subtraction
  //   trial = {prem, next two operand bits} - {proot, 01}
  // The decision compares the full-width minuend and subtrahend, so no bit of
  // the partial remainder is dropped before the sign is known. When the
  // subtraction succeeds, the difference is at most 2*new_root. That always fits
  // in N+1 bits, so the low N+1 bits of a modular subtraction are exact.
  // ---------------------------------------------------------------------------
  logic [1:0]   pair;
  logic [N+2:0] trial_lhs;
  logic [N+2:0] trial_rhs;
  logic         trial_ok;    // trial >= 0
  logic [N:0]   trial_low;   // trial[N:0]
  logic [N:0]   shifted_rem; // remainder when the trial fails

  always_comb begin
    pair        = opr_q[2*N-1 -: 2];
    trial_lhs   = {prem_q, pair};
    trial_rhs   = {1'b0, proot_q, 2'b01};
    trial_ok    = (trial_lhs >= trial_rhs);
    trial_low   = trial_lhs[N:0] - trial_rhs[N:0];
    // When the trial fails, the remainder is below 4*proot+1 < 2^(N+1).
    // Dropping the top two bits of prem therefore loses nothing.
    shifted_rem = {prem_q[N-2:0], pair};
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    opr_d   = opr_q;
    proot_d = proot_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    rem_d   = rem_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          opr_d   = X;
          proot_d = '0;
          prem_d  = '0;
          cnt_d   = CNT_LOAD;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        if (trial_ok) begin
          prem_d  = trial_low;
          proot_d = {proot_q[N-2:0], 1'b1};
        end else begin
          prem_d  = shifted_rem;
          proot_d = {proot_q[N-2:0], 1'b0};
        end
        opr_d = opr_q << 2;

        if (cnt_q == '0) begin
          // Publish the value of this final step, not the stale one.
          root_d  = proot_d;
          rem_d   = prem_d;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DONE: begin
        // start is ignored here. A new request is only seen back in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opr_q   <= '0;
      proot_q <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
      proot_q <= proot_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign root = root_q;
  assign rem  = rem_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// -----------------------------------------------------------------------------
// tb_isqrt_seq
// -----------------------------------------------------------------------------
// Directed bench for isqrt_seq. It uses two instances: N=8 for the main cases
// and N=4 for an exhaustive sweep of every operand. Each comparison is an
// immediate assertion. Expected values are hand-computed constants or the
// defining relation X = root*root + rem with rem <= 2*root.
// -----------------------------------------------------------------------------
module tb_isqrt_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, start4;
  logic [15:0] x8;
  logic [7:0]  x4;
  logic        busy8, done8, busy4, done4;
  logic [7:0]  root8;
  logic [8:0]  rem8;
  logic [3:0]  root4;
  logic [4:0]  rem4;

  isqrt_seq #(.N(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .X     (x8),
    .busy  (busy8),
    .done  (done8),
    .root  (root8),
    .rem   (rem8)
  );

  isqrt_seq #(.N(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .X     (x4),
    .busy  (busy4),
    .done  (done4),
    .root  (root4),
    .rem   (rem4)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one N=8 operation. The task returns the result seen in the done cycle,
  // the cycle on which done appeared (counted from the accepting edge), and the
  // number of busy cycles. X is scrambled while busy.
  task automatic op8(input logic [15:0] x, output logic [7:0] r, output logic [8:0] m,
                     output int lat, output int bcnt);
    @(negedge clk);
    x8     = x;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    x8     = ~x;
    lat    = 1;
    bcnt   = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy8 === 1'b1) bcnt++;
    r = root8;
    m = rem8;
  endtask

  task automatic op4(input logic [7:0] x, output logic [3:0] r, output logic [4:0] m,
                     output int lat);
    @(negedge clk);
    x4     = x;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    x4     = ~x;
    lat    = 1;
    while (done4 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r = root4;
    m = rem4;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0]  r8;
  logic [8:0]  m8;
  logic [3:0]  r4;
  logic [4:0]  m4;
  int          lat, bc;
  int          pulses, cyc, last_done;
  int          pulse_cyc [3];
  logic [15:0] rx;
  logic [15:0] dx   [8] = '{16'd144, 16'd143, 16'd65535, 16'd65025, 16'd256, 16'd1, 16'd2, 16'd3};
  logic [7:0]  droot[8] = '{8'd12,  8'd11,  8'd255,  8'd255,  8'd16,  8'd1, 8'd1, 8'd1};
  logic [8:0]  drem [8] = '{9'd0,   9'd22,  9'd510,  9'd0,    9'd0,   9'd0, 9'd1, 9'd2};

  initial begin
    rst    = 1'b1;
    start8 = 1'b0;
    start4 = 1'b0;
    x8     = '0;
    x4     = '0;
    repeat (3) @(negedge clk);
    // The reset state is checked while start is high. rst must win.
    start8 = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    chk("reset_root", root8, 0);
    chk("reset_rem",  rem8,  0);
    start8 = 1'b0;
    rst    = 1'b0;

    // X = 0: done 9 cycles after the accepting edge, busy for 9 cycles.
    op8(16'd0, r8, m8, lat, bc);
    chk("x0_latency", lat, 9);
    chk("x0_busy_cycles", bc, 9);
    chk("x0_root", r8, 0);
    chk("x0_rem",  m8, 0);
    @(negedge clk);
    chk("x0_idle_busy", busy8, 0);
    chk("x0_done_pulse_width", done8, 0);
    $display("op X=0 root=%0d rem=%0d lat=%0d", r8, m8, lat);

    // Directed operands, including both boundaries and perfect squares.
    for (int i = 0; i < 8; i++) begin
      op8(dx[i], r8, m8, lat, bc);
      chk($sformatf("dir%0d_latency", i), lat, 9);
      chk($sformatf("dir%0d_root", i), r8, droot[i]);
      chk($sformatf("dir%0d_rem", i),  m8, drem[i]);
      $display("op X=%0d root=%0d rem=%0d lat=%0d", dx[i], r8, m8, lat);
    end

    // In IDLE, the outputs keep the last result (X=3 -> 1/2).
    repeat (5) @(negedge clk);
    chk("idle_hold_root", root8, 1);
    chk("idle_hold_rem",  rem8,  2);

    // A start pulse during CALC, with X=4, is ignored.
    @(negedge clk);
    x8     = 16'd143;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    x8     = 16'd4;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    pulses = 0;
    r8     = '0;
    m8     = '0;
    for (int i = 0; i < 30; i++) begin
      if (done8 === 1'b1) begin
        pulses++;
        r8 = root8;
        m8 = rem8;
      end
      @(negedge clk);
    end
    chk("ignore_pulses", pulses, 1);
    chk("ignore_root", r8, 11);
    chk("ignore_rem",  m8, 22);
    $display("op X=143 with stray start root=%0d rem=%0d pulses=%0d", r8, m8, pulses);

    // Hold start high with X=100. Done must pulse every N+2 cycles.
    @(negedge clk);
    x8        = 16'd100;
    start8    = 1'b1;
    pulses    = 0;
    last_done = 0;
    cyc       = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (last_done != 0) begin
        chk($sformatf("held_busy_after_done%0d", pulses), busy8, 0);
        last_done = 0;
        if (pulses == 3) break;
      end
      if (done8 === 1'b1) begin
        pulse_cyc[pulses] = cyc;
        chk($sformatf("held_root%0d", pulses), root8, 10);
        chk($sformatf("held_rem%0d", pulses),  rem8,  0);
        pulses++;
        last_done = 1;
      end
    end
    start8 = 1'b0;
    chk("held_pulses", pulses, 3);
    chk("held_first", pulse_cyc[0], 9);
    chk("held_gap1", pulse_cyc[1] - pulse_cyc[0], 10);
    chk("held_gap2", pulse_cyc[2] - pulse_cyc[1], 10);
    $display("op X=100 held start pulses at %0d %0d %0d", pulse_cyc[0], pulse_cyc[1], pulse_cyc[2]);

    // A reset during iteration 4 of X=50000 aborts the operation with no done.
    @(negedge clk);
    x8     = 16'd50000;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_root", root8, 0);
    chk("abort_rem",  rem8,  0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    op8(16'd50000, r8, m8, lat, bc);
    chk("after_abort_latency", lat, 9);
    chk("after_abort_root", r8, 223);
    chk("after_abort_rem",  m8, 271);
    $display("op X=50000 after abort root=%0d rem=%0d lat=%0d", r8, m8, lat);

    // Random operands. Each result is checked against the defining relation.
    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom_range(0, 65535));
      op8(rx, r8, m8, lat, bc);
      chk($sformatf("rnd%0d_latency", i), lat, 9);
      chk($sformatf("rnd%0d_relation", i), int'(r8) * int'(r8) + int'(m8), int'(rx));
      chk($sformatf("rnd%0d_rem_bound", i), (int'(m8) <= 2 * int'(r8)) ? 1 : 0, 1);
      $display("op X=%0d root=%0d rem=%0d", rx, r8, m8);
    end

    // Exhaustive sweep of the N=4 build.
    for (int v = 0; v < 256; v++) begin
      op4(8'(v), r4, m4, lat);
      chk($sformatf("n4_%0d_latency", v), lat, 5);
      chk($sformatf("n4_%0d_relation", v), int'(r4) * int'(r4) + int'(m4), v);
      chk($sformatf("n4_%0d_rem_bound", v), (int'(m4) <= 2 * int'(r4)) ? 1 : 0, 1);
      $display("op4 X=%0d root=%0d rem=%0d", v, r4, m4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
